// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int PWM_PHASES = 16;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] ANODE_OFF = 8'hFF;

    // One register-file entry: decimal point plus hex value.
    typedef struct packed {
        logic       dp;
        logic [3:0] value;
    } digit_t;

endpackage

// File: rtl/seg_decode.sv
// Hex to seven-segment decoder, active-low segments ordered {g,f,e,d,c,b,a}.
module seg_decode (
    input  logic [3:0] value,
    output logic [6:0] seg
);

    // Pure lookup; every value has a defined glyph.
    always_comb begin
        seg = 7'b1111111;
        case (value)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0011000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for the 8-digit multiplexed display: refresh prescaler,
// enabled-digit slot sequence, double-buffered digit file and PWM dimming.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_DIV = 200000,
    parameter int DIV_W   = 18
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       wr_dp,
    input  logic [7:0] en_mask,
    input  logic [3:0] brightness,
    input  logic       freeze,
    output logic [7:0] Anode_Activate,
    output logic [6:0] LED_out,
    output logic       DP_out,
    output logic [2:0] slot,
    output logic       frame_done
);

    localparam int SUB_LEN = CLK_DIV / PWM_PHASES;
    localparam logic [DIV_W-1:0] SUB_MAX = DIV_W'(SUB_LEN - 1);

    logic [DIV_W-1:0] sub_cnt;
    logic [3:0]       phase;
    logic [2:0]       slot_q;
    logic             rdy_q;
    digit_t           shadow  [NUM_DIGITS];
    digit_t           display [NUM_DIGITS];

    logic       tick;
    logic       advance;
    logic       wrap;
    logic       rdy_now;
    logic       wr_fire;
    logic [2:0] next_slot;
    logic [6:0] seg_dec;

    logic [7:0] anode_p1;
    logic [6:0] led_p1;
    logic       dp_p1;

    // First enabled digit after cur, searched cur+1 .. cur+8 modulo 8.
    function automatic logic [2:0] find_next(input logic [2:0] cur, input logic [7:0] mask);
        logic [2:0] idx;
        logic [2:0] res;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k <= NUM_DIGITS; k++) begin
            idx = cur + 3'(k);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Slot-advance decision; a wrap also closes the write port for one cycle.
    always_comb begin
        next_slot = find_next(slot_q, en_mask);
        tick      = (sub_cnt == SUB_MAX) && (phase == 4'hF);
        advance   = tick && (en_mask != 8'h00) && !freeze;
        wrap      = advance && (next_slot <= slot_q);
        rdy_now   = rdy_q && !wrap;
        wr_fire   = wr_valid && rdy_now;
    end

    // Prescaler: sub counts one PWM phase, phase counts sixteen per slot.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            sub_cnt <= '0;
            phase   <= '0;
        end else if (sub_cnt == SUB_MAX) begin
            sub_cnt <= '0;
            phase   <= phase + 4'd1;
        end else begin
            sub_cnt <= sub_cnt + 1'b1;
        end
    end

    // Slot register and the write-port enable that comes up after reset.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            slot_q <= '0;
            rdy_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (advance) slot_q <= next_slot;
        end
    end

    // Shadow bank takes host writes at any time the port is open.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= '0;
        end else if (wr_fire) begin
            shadow[wr_addr] <= {wr_dp, wr_data};
        end
    end

    // Display bank only changes at a frame wrap so a frame never tears.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) display[i] <= '0;
        end else if (wrap) begin
            display <= shadow;
        end
    end

    seg_decode u_decode (
        .value (display[slot_q].value),
        .seg   (seg_dec)
    );

    // Output stage p1: anode and cathode register on the same edge.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            anode_p1 <= ANODE_OFF;
            led_p1   <= SEG_BLANK;
            dp_p1    <= 1'b1;
        end else begin
            anode_p1 <= (en_mask[slot_q] && (phase <= brightness)) ? ~(8'b1 << slot_q) : ANODE_OFF;
            led_p1   <= seg_dec;
            dp_p1    <= ~display[slot_q].dp;
        end
    end

    assign Anode_Activate = anode_p1;
    assign LED_out        = led_p1;
    assign DP_out         = dp_p1;
    assign slot           = slot_q;
    assign frame_done     = wrap;
    assign wr_ready       = rdy_now;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: per-cycle reference model feeding a scoreboard
// queue, plus directed scenarios around frame wrap, PWM, freeze and reset.
module tb_seg_scan_ctrl;

    localparam int CLK_DIV = 32;
    localparam int DIV_W   = 6;
    localparam int PH_LEN  = CLK_DIV / 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic [7:0] en_mask;
    logic [3:0] brightness;
    logic       freeze;
    logic [7:0] Anode_Activate;
    logic [6:0] LED_out;
    logic       DP_out;
    logic [2:0] slot;
    logic       frame_done;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) dut (
        .CLK100MHZ      (clk),
        .reset          (reset),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_dp          (wr_dp),
        .en_mask        (en_mask),
        .brightness     (brightness),
        .freeze         (freeze),
        .Anode_Activate (Anode_Activate),
        .LED_out        (LED_out),
        .DP_out         (DP_out),
        .slot           (slot),
        .frame_done     (frame_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference glyphs, active-low {g,f,e,d,c,b,a}.
    logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [7:0] an;
        logic [6:0] led;
        logic       dp;
        logic [2:0] slot;
        logic       fd;
        logic       rdy;
    } exp_t;

    exp_t q[$];

    // Behavioural model: one cycle counter per slot, a mask search, two banks.
    int         m_t;
    int         m_slot;
    bit         m_rdy;
    logic [4:0] m_shadow [8];
    logic [4:0] m_disp   [8];

    always @(posedge clk) begin
        exp_t e;
        int   ph;
        int   nxt;
        bit   tck;
        bit   adv;
        bit   wrp;
        if (reset) begin
            m_t = 0;
            m_slot = 0;
            m_rdy = 0;
            for (int i = 0; i < 8; i++) begin
                m_shadow[i] = '0;
                m_disp[i] = '0;
            end
        end else begin
            ph = m_t / PH_LEN;
            e.an  = (en_mask[m_slot] && ph <= int'(brightness)) ? ~(8'(1) << m_slot) : 8'hFF;
            e.led = seg_ref[m_disp[m_slot][3:0]];
            e.dp  = ~m_disp[m_slot][4];
            tck = (m_t == CLK_DIV - 1);
            nxt = m_slot;
            for (int k = 1; k <= 8; k++) begin
                if (en_mask[(m_slot + k) % 8]) begin
                    nxt = (m_slot + k) % 8;
                    break;
                end
            end
            adv = tck && (en_mask != 8'h00) && !freeze;
            wrp = adv && (nxt <= m_slot);
            e.fd  = wrp;
            e.rdy = m_rdy && !wrp;
            if (e.rdy && wr_valid) m_shadow[wr_addr] = {wr_dp, wr_data};
            if (wrp) m_disp = m_shadow;
            m_t = (m_t + 1) % CLK_DIV;
            if (adv) m_slot = nxt;
            m_rdy = 1;
            e.slot = m_slot[2:0];
            q.push_back(e);
        end
    end

    // Monitor: registered outputs against the newest record; frame_done and
    // wr_ready against the sample taken during the cycle that record closed.
    logic prev_fd;
    logic prev_rdy;
    bit   prev_ok = 0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            q.delete();
            prev_ok = 0;
        end else begin
            if (q.size() > 0) begin
                e = q.pop_front();
                check("anode", Anode_Activate, e.an);
                check("led", LED_out, e.led);
                check("dp", DP_out, e.dp);
                check("slot", slot, e.slot);
                if (prev_ok) begin
                    check("frame_done", prev_fd, e.fd);
                    check("wr_ready", prev_rdy, e.rdy);
                end
            end
            prev_fd  = frame_done;
            prev_rdy = wr_ready;
            prev_ok  = 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_slot(input int n);
        int prev;
        bit hit;
        prev = int'(slot);
        hit = 0;
        for (int c = 0; c < 2 * 8 * CLK_DIV; c++) begin
            @(negedge clk);
            if (int'(slot) == n && prev != n) begin
                hit = 1;
                break;
            end
            prev = int'(slot);
        end
        if (!hit) check("wait_slot_timeout", 0, 1);
    endtask

    task automatic wait_new_slot(output int s);
        int prev;
        bit hit;
        prev = int'(slot);
        hit = 0;
        s = prev;
        for (int c = 0; c < 2 * CLK_DIV; c++) begin
            @(negedge clk);
            if (int'(slot) != prev) begin
                hit = 1;
                s = int'(slot);
                break;
            end
        end
        if (!hit) check("wait_new_slot_timeout", 0, 1);
    endtask

    task automatic frame_period(input int cycles, input int period);
        int last;
        int seen;
        last = -1;
        seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (frame_done) begin
                if (last >= 0) check("frame_period", c - last, period);
                last = c;
                seen++;
            end
        end
        check("frames_seen", seen >= 2, 1);
    endtask

    task automatic count_on(input int s, input int cycles, output int on, output bit first_on);
        logic [7:0] pat;
        pat = ~(8'(1) << s);
        on = 0;
        first_on = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (Anode_Activate == pat) begin
                on++;
                if (c == 0) first_on = 1;
            end
        end
    endtask

    initial begin
        int  s;
        int  on;
        bit  first_on;
        int  fd_cnt;
        int  slot_moves;
        int  low_cnt;
        int  lit;
        logic [2:0] held;

        reset = 1; wr_valid = 0; wr_addr = 0; wr_data = 0; wr_dp = 0;
        en_mask = 8'hFF; brightness = 4'hF; freeze = 0;
        #2;
        check("rst_anode", Anode_Activate, 8'hFF);
        check("rst_led", LED_out, 7'h7F);
        check("rst_dp", DP_out, 1'b1);
        check("rst_fd", frame_done, 1'b0);
        check("rst_rdy", wr_ready, 1'b0);
        check("rst_slot", slot, 3'd0);
        repeat (3) @(posedge clk);
        #1 reset = 0;

        // All digits enabled, full brightness: one frame every 8 slots.
        frame_period(800, 8 * CLK_DIV);

        // Sparse mask 0,2,5: three slots per frame.
        @(posedge clk); #1 en_mask = 8'b0010_0101;
        frame_period(400, 3 * CLK_DIV);

        // Mid-frame write to digit 3 stays hidden until the wrap.
        @(posedge clk); #1 en_mask = 8'hFF;
        wait_slot(1);
        @(posedge clk); #1 wr_valid = 1; wr_addr = 3'd3; wr_data = 4'hA; wr_dp = 0;
        @(posedge clk); #1 wr_valid = 0;
        wait_slot(3);
        @(negedge clk); @(negedge clk);
        check("digit3_before_wrap", LED_out, 7'h40);
        wait_slot(3);
        @(negedge clk); @(negedge clk);
        check("digit3_after_wrap", LED_out, 7'h08);

        // A write raised during the wrap cycle is taken the cycle after.
        for (int c = 0; c < 16 * CLK_DIV; c++) begin
            @(negedge clk);
            if (frame_done) break;
        end
        check("wrap_seen", frame_done, 1'b1);
        wr_valid = 1; wr_addr = 3'd6; wr_data = 4'h7; wr_dp = 1;
        check("rdy_low_on_wrap", wr_ready, 1'b0);
        @(negedge clk);
        check("rdy_after_wrap", wr_ready, 1'b1);
        @(posedge clk); #1 wr_valid = 0;

        // PWM: brightness 3 -> 8 of 32 cycles, brightness 0 -> 2 of 32.
        brightness = 4'd3;
        wait_new_slot(s);
        wait_new_slot(s);
        count_on(s, CLK_DIV, on, first_on);
        check("pwm_b3_on", on, 8);
        check("pwm_b3_starts_on", first_on, 1);
        brightness = 4'd0;
        wait_new_slot(s);
        wait_new_slot(s);
        count_on(s, CLK_DIV, on, first_on);
        check("pwm_b0_on", on, 2);
        check("pwm_b0_starts_on", first_on, 1);

        // Freeze: slot holds, no frame_done, PWM keeps toggling.
        brightness = 4'd3;
        @(posedge clk); #1 freeze = 1;
        @(negedge clk);
        held = slot;
        fd_cnt = 0; slot_moves = 0; low_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
            if (slot != held) slot_moves++;
            if (Anode_Activate != 8'hFF) low_cnt++;
        end
        check("freeze_slot_moves", slot_moves, 0);
        check("freeze_fd", fd_cnt, 0);
        check("freeze_pwm_running", (low_cnt > 0) && (low_cnt < 100), 1);

        // No digits enabled: anodes stay off and slot stays put.
        @(posedge clk); #1 freeze = 0; en_mask = 8'h00;
        @(negedge clk);
        held = slot;
        lit = 0; slot_moves = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (Anode_Activate != 8'hFF) lit++;
            if (slot != held) slot_moves++;
        end
        check("mask0_anode_lit", lit, 0);
        check("mask0_slot_moves", slot_moves, 0);

        // Asynchronous reset while digit 5 is lit.
        @(posedge clk); #1 en_mask = 8'hFF; brightness = 4'hF;
        wait_slot(5);
        @(negedge clk); @(negedge clk);
        check("pre_reset_anode", Anode_Activate, 8'hDF);
        @(posedge clk); #3 reset = 1;
        #1;
        check("async_rst_anode", Anode_Activate, 8'hFF);
        check("async_rst_led", LED_out, 7'h7F);
        check("async_rst_dp", DP_out, 1'b1);
        check("async_rst_slot", slot, 3'd0);
        check("async_rst_rdy", wr_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("post_rst_rdy_low", wr_ready, 1'b0);
        check("post_rst_slot", slot, 3'd0);
        @(negedge clk);
        check("post_rst_rdy_high", wr_ready, 1'b1);
        check("post_rst_digit0", LED_out, 7'h40);

        // Randomised traffic: masks, dimming, freezes and writes.
        for (int seg_i = 0; seg_i < 40; seg_i++) begin
            @(posedge clk); #1;
            en_mask    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            brightness = 4'($urandom);
            freeze     = ($urandom_range(0, 7) == 0);
            for (int c = 0; c < 60; c++) begin
                wr_valid = $urandom_range(0, 1) == 1;
                wr_addr  = 3'($urandom);
                wr_data  = 4'($urandom);
                wr_dp    = 1'($urandom);
                @(posedge clk); #1;
            end
        end
        wr_valid = 0; freeze = 0; en_mask = 8'hFF;
        repeat (8 * CLK_DIV + 4) @(posedge clk);
        @(negedge clk);
        check("scoreboard_active", n_checks > 5000, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Scan scheduler for the 8-digit multiplexed seven-segment display. It owns the refresh prescaler, the digit slot sequence, a double-buffered digit register file written through a valid/ready port, per-digit enables and PWM brightness. It drives the active-low anode and cathode pins directly, using an internal hex decoder. It replaces ad-hoc refresh dividers in the top level.

Parameters:
CLK_DIV, 200000, clocks per digit slot (100 MHz / 200000 = 2 ms). Must be a multiple of 16 and at least 32.
DIV_W, 18, prescaler width; must satisfy 2**DIV_W >= CLK_DIV.

Ports:
CLK100MHZ  in  1  system clock
reset  in  1  asynchronous, active-high reset
wr_valid  in  1  write request
wr_ready  out  1  write accept; a transfer occurs when wr_valid and wr_ready are both high on a rising edge
wr_addr  in  3  digit index (0 = rightmost)
wr_data  in  4  hex digit value
wr_dp  in  1  decimal point for the digit (1 = lit)
en_mask  in  8  per-digit enable; bit i enables digit i
brightness  in  4  on-phases per slot minus 1 (0 = 1/16 duty, 15 = 100%)
freeze  in  1  hold the current slot
Anode_Activate  out  8  active-low anodes, one-hot-low or all high
LED_out  out  7  active-low cathodes {g,f,e,d,c,b,a}
DP_out  out  1  active-low decimal point
slot  out  3  current digit index
frame_done  out  1  one-cycle pulse at frame wrap

Behaviour:
- Reset (asynchronous, immediate):
  - Prescaler, phase and slot are 0.
  - Shadow and display banks are all 0 with dp = 0.
  - Anode_Activate = 8'hFF, LED_out = 7'h7F, DP_out = 1, frame_done = 0, wr_ready = 0.
  - wr_ready rises in the first cycle after reset deasserts.
- Prescaler: a sub counter runs 0..CLK_DIV/16-1; on wrap, phase (4 bits) increments 0..15.
  - tick = sub at max and phase == 15, i.e. once every CLK_DIV cycles.
- Slot advance on tick:
  - Next slot is the first enabled index after the current one, searched modulo 8 (current+1 ... current+8).
  - Index 7 wraps to 0. No ninth state exists.
  - If en_mask == 0: slot holds and there is no frame_done.
  - If freeze == 1: slot holds, there is no frame_done and no bank copy. Prescaler and PWM keep running.
- Frame wrap: a tick where next slot <= current slot (this includes a single enabled digit).
  - frame_done pulses in that cycle.
  - The display bank copies the shadow bank in that same cycle.
  - wr_ready is 0 in that cycle only.
- Writes: an accepted transfer updates shadow[wr_addr] = {wr_dp, wr_data} at the clock edge.
  - A write accepted during a frame becomes visible only after the next frame wrap.
  - Back-to-back writes are accepted every cycle except the copy cycle.
  - The last write to an address before the copy wins.
- Anode drive: digit `slot` is active when en_mask[slot] == 1 and phase <= brightness. Otherwise all anodes are high.
- Cathode drive: LED_out = decode(display[slot].value); DP_out = ~display[slot].dp.
- Output timing: all outputs are registered, one cycle after the internal slot/phase state. Anode and cathode always change on the same edge, so there is no ghosting.
- Changes to en_mask and brightness are sampled every cycle.
  - Disabling the current digit blanks it on the next registered cycle.
  - The slot sequence uses the new mask at the next tick.
- Decode table: values 0-9 are the standard digits (0 = 1000000, 1 = 1111001, 8 = 0000000, 9 = 0011000).
  - A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
- slot output equals the internal slot register.

Decomposition:
- Package seg_pkg holds:
  - NUM_DIGITS = 8 and PWM_PHASES = 16;
  - SEG_BLANK = 7'h7F and ANODE_OFF = 8'hFF;
  - the digit entry typedef {dp, value[3:0]}.
- Sub-module seg_decode: purely combinational, 4-bit value in, 7-bit active-low segments out.
- Slot search, prescaler and both banks remain in seg_scan_ctrl.

Test Plan:
1. Bench uses CLK_DIV = 32. Reset, then en_mask = FF, brightness = 15. Required: Anode_Activate steps FE, FD, FB, ... 7F, holding each value 32 cycles; frame_done pulses every 256 cycles; the pattern is back to FE after 7F.
2. en_mask = 8'b00100101. Required: slot sequence 0, 2, 5, 0, 2, ... with 32 cycles per slot; frame_done only on the 5->0 tick.
3. Write addr 3 = A mid-frame. Required: slot 3 shows LED_out 1000000 until the frame wrap, then 0001000. wr_ready is 0 only on the frame_done cycle. A write held across that cycle is accepted in the next cycle.
4. brightness = 3. Required: the active anode is low for 8 of 32 cycles per slot, starting at the slot start. brightness = 0 gives 2 of 32 cycles.
5. freeze = 1 for 100 cycles. Required: slot is constant, no frame_done, anode PWM continues. en_mask = 0 gives Anode_Activate = FF, slot static.
6. Assert reset mid-slot with digit 5 active. Required: outputs are FF / 7F / 1 immediately, asynchronously. After release: slot = 0, all digits read 0, wr_ready = 1 one cycle later.
